add_sub_serial: RTL
===================

# add_sub_serial

Parametrised bit-serial adder/subtractor: a multi-cycle unit that adds or subtracts two WIDTH-bit operands one bit per clock through a single registered full-adder stage. It generalises the combinational half/full-adder cells of the 4-bit add/sub datapath: operand width becomes a parameter, the add/sub mode is selected per operation, and a start/done handshake is added. Carry and signed-overflow flags are produced alongside the sum.

## Interface
- WIDTH, 4, operand and result width in bits; legal range ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled on rising clk
- sub  input  1  0 = A+B, 1 = A−B; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when S/C/V become valid
- S  output  WIDTH  result, registered, held until next accepted start
- C  output  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned)
- V  output  1  two's-complement overflow

## Operation
- One clock; reset is asynchronous and active-low (rst_n).
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch A into shift reg a_sr, latch B^{WIDTH{sub}} into b_sr, carry reg ← sub, bit counter ← 0, S reg ← 0; go to RUN. start=0 → stay.
- RUN: each cycle computes full-adder sum/carry of a_sr[0], b_sr[0], carry; sum bit shifts into S reg at MSB (S shifts right); a_sr, b_sr shift right; carry reg ← carry out; counter increments.
- The cycle processing bit WIDTH−1 also records V = carry into MSB XOR carry out of MSB. C ← final carry. Next state is DONE.
- DONE: done=1 for exactly this cycle. start=1 → accept new operation as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- start while in RUN is ignored; A/B/sub changes during RUN have no effect.
- Counter width $clog2(WIDTH); terminal count WIDTH−1; no wrap beyond it.
- Arithmetic is modulo 2^WIDTH; S is identical to the low WIDTH bits of A+B or A+~B+1.
- busy = (state == RUN); done = (state == DONE).

## Timing
- Reset values (asynchronous, immediate on rst_n low): state IDLE, busy 0, done 0, S 0, C 0, V 0, shift regs and counter 0.
- Reset asserted mid-RUN aborts the operation; no done pulse is produced. The first start after rst_n deasserts is accepted normally.
- Start accepted at edge 0 → busy high from edge 0 to edge WIDTH. Bits are processed at edges 1..WIDTH. done is high from edge WIDTH to edge WIDTH+1. Latency is WIDTH+1 edges from accepting start to done falling.
- S/C/V are valid and stable from the edge that raises done until the edge that accepts the next start.
- Throughput with back-to-back start: one result per WIDTH+1 cycles.
- S, C and V bits are intermediate while busy=1 and must not be sampled then.

## Test plan
- WIDTH=4, add 7+5 → after 4 busy cycles done pulses once; S=1100, C=0, V=1.
- WIDTH=4, sub 3−5 → S=1110, C=0, V=0. Then sub 5−3 → S=0010, C=1, V=0.
- WIDTH=4 wrap-around: add 15+1 → S=0000, C=1, V=0. Sub 8−1 (−8−1) → S=0111, C=1, V=1.
- Hold start=1 continuously with changing A/B → inputs are accepted only in IDLE/DONE. done pulses every 5 cycles; each result matches the operands latched at its accept edge.
- Assert rst_n low during the 2nd RUN cycle → all outputs 0 immediately; no done pulse. After release, 2+2 yields S=0100 with correct latency.
- WIDTH=8, exhaustive or random sweep of A, B, sub against a reference model: S, C and V match. Each operation's done arrives exactly 8 edges after start is accepted.

Source files
------------

// File: rtl/add_sub_serial.sv
// add_sub_serial
//   Bit-serial adder/subtractor. One full-adder stage processes one operand
//   bit per clock, LSB first. Subtraction is done as A + ~B + 1 by inverting
//   B at accept time and seeding the carry register with 1.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (accepted in IDLE or DONE)
//   sub    in   0: A+B, 1: A-B (sampled with start)
//   A, B   in   WIDTH-bit operands (sampled with start)
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when S/C/V are valid
//   S      out  WIDTH-bit result, held until the next accepted start
//   C      out  carry out of MSB (for subtract: 1 = no borrow)
//   V      out  two's-complement overflow
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per clock, WIDTH cycles
// DONE  | results valid, done pulse; start here chains the next operation
module add_sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic accept;
  logic last_bit;
  logic sum_bit;
  logic carry_out;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_out = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
      S     <= '0;
    end else if (state == RUN) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      carry <= carry_out;
      // sum enters at the MSB so bit 0 ends up in S[0] after WIDTH shifts
      S     <= {sum_bit, S[WIDTH-1:1]};
      if (last_bit) begin
        C <= carry_out;
        // carry into the MSB is the carry register on this cycle
        V <= carry ^ carry_out;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
